// File: rtl/bear_ship_serial_tx.sv
// bear_ship_serial_tx: two-lane bearing/heading serial transmitter (Dat/Clk/Lt per lane).
// Rev 1.0 - initial release.
`default_nettype none

module bear_ship_serial_tx #(
  parameter int BEAR_W  = 12,
  parameter int SHIP_W  = 8,
  parameter int CLK_DIV = 4
) (
  input  logic              Clk,
  input  logic              nReset,
  input  logic              Start,
  input  logic [BEAR_W-1:0] Bear,
  input  logic [SHIP_W-1:0] Ship,
  output logic              Busy,
  output logic              Done,
  output logic [7:0]        FrameCount,
  output logic [1:0]        PdoDat,
  output logic [1:0]        PdoClk,
  output logic [1:0]        PdoLt
);

  localparam int HW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int BW = $clog2(BEAR_W + 1);
  localparam logic [HW-1:0] HALF_LAST = HW'(CLK_DIV - 1);
  localparam logic [BW-1:0] BEAR_BITS = BW'(BEAR_W);
  localparam logic [BW-1:0] SHIP_BITS = BW'(SHIP_W);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    SHIFT_LO = 2'd1,
    SHIFT_HI = 2'd2,
    LATCH    = 2'd3
  } state_t;

  state_t            state;
  logic [HW-1:0]     half_cnt;
  logic [BW-1:0]     bit_cnt;
  logic [BEAR_W-1:0] bear_sr;
  logic [SHIP_W-1:0] ship_sr;

  logic [BEAR_W-1:0] bear_next;
  logic [SHIP_W-1:0] ship_next;
  logic [BW-1:0]     bit_next;
  logic              half_done;

  assign bear_next = bear_sr << 1;
  assign ship_next = ship_sr << 1;
  assign bit_next  = bit_cnt + BW'(1);
  assign half_done = (half_cnt == HALF_LAST);

  always_ff @(posedge Clk or negedge nReset) begin
    if (!nReset) begin
      state      <= IDLE;
      half_cnt   <= '0;
      bit_cnt    <= '0;
      bear_sr    <= '0;
      ship_sr    <= '0;
      Busy       <= 1'b0;
      Done       <= 1'b0;
      FrameCount <= '0;
      PdoDat     <= '0;
      PdoClk     <= '0;
      PdoLt      <= '0;
    end else begin
      Done <= 1'b0;
      case (state)
        IDLE: begin
          half_cnt <= '0;
          if (Start) begin
            bear_sr  <= Bear;
            ship_sr  <= Ship;
            bit_cnt  <= '0;
            PdoDat   <= {Ship[SHIP_W-1], Bear[BEAR_W-1]};
            PdoClk   <= 2'b00;
            PdoLt    <= 2'b00;
            Busy     <= 1'b1;
            state    <= SHIFT_LO;
          end
        end

        SHIFT_LO: begin
          if (half_done) begin
            half_cnt <= '0;
            // Ship lane clock only runs while heading bits remain
            PdoClk   <= {(bit_cnt < SHIP_BITS), 1'b1};
            state    <= SHIFT_HI;
          end else begin
            half_cnt <= half_cnt + HW'(1);
          end
        end

        SHIFT_HI: begin
          if (half_done) begin
            half_cnt <= '0;
            bear_sr  <= bear_next;
            ship_sr  <= ship_next;
            bit_cnt  <= bit_next;
            PdoClk   <= 2'b00;
            if (bit_next < BEAR_BITS) begin
              PdoDat <= {(bit_next < SHIP_BITS) ? ship_next[SHIP_W-1] : 1'b0,
                         bear_next[BEAR_W-1]};
              state  <= SHIFT_LO;
            end else begin
              PdoDat <= 2'b00;
              PdoLt  <= 2'b11;
              state  <= LATCH;
            end
          end else begin
            half_cnt <= half_cnt + HW'(1);
          end
        end

        LATCH: begin
          if (half_done) begin
            half_cnt   <= '0;
            PdoLt      <= 2'b00;
            Done       <= 1'b1;
            Busy       <= 1'b0;
            FrameCount <= FrameCount + 8'd1;
            state      <= IDLE;
          end else begin
            half_cnt <= half_cnt + HW'(1);
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_bear_ship_serial_tx.sv
// tb_bear_ship_serial_tx: directed, table-driven bench for bear_ship_serial_tx.
// Rev 1.0 - initial release.
`default_nettype none

module tb_bear_ship_serial_tx;

  logic        Clk = 1'b0;
  logic        nReset;
  logic        Start;
  logic [11:0] Bear;
  logic [7:0]  Ship;
  logic        Busy, Done;
  logic [7:0]  FrameCount;
  logic [1:0]  PdoDat, PdoClk, PdoLt;

  int checks = 0;
  int errors = 0;

  // frame observations gathered by observe()
  logic [11:0] cap_bear;
  logic [7:0]  cap_ship;
  int          rise0, rise1, lt_cycles, done_k, first_rise;
  logic        ship_late, busy_drop, done_busy;

  typedef struct {
    logic [11:0] bear;
    logic [7:0]  ship;
    logic [11:0] exp_bear;
    logic [7:0]  exp_ship;
  } vec_t;

  vec_t vecs [5];

  bear_ship_serial_tx #(.BEAR_W(12), .SHIP_W(8), .CLK_DIV(4)) dut (
    .Clk       (Clk),
    .nReset    (nReset),
    .Start     (Start),
    .Bear      (Bear),
    .Ship      (Ship),
    .Busy      (Busy),
    .Done      (Done),
    .FrameCount(FrameCount),
    .PdoDat    (PdoDat),
    .PdoClk    (PdoClk),
    .PdoLt     (PdoLt)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Called 1ns after an edge with the DUT idle; returns 1ns after the accepting edge T.
  task automatic kick(input logic [11:0] b, input logic [7:0] s);
    Bear  = b;
    Ship  = s;
    Start = 1'b1;
    @(posedge Clk); #1;
    Start = 1'b0;
  endtask

  // k counts edges after T; values seen at k are the ones in cycle T+k+1.
  task automatic observe(input int mid_k, input logic chain,
                         input logic [11:0] nb, input logic [7:0] ns);
    logic [1:0] prev_clk;
    cap_bear = '0; cap_ship = '0;
    rise0 = 0; rise1 = 0; lt_cycles = 0; done_k = -1; first_rise = -1;
    ship_late = 1'b0; busy_drop = 1'b0; done_busy = 1'b1;
    prev_clk = PdoClk;
    for (int k = 1; k <= 200; k++) begin
      @(posedge Clk); #1;
      if (k == mid_k - 1) begin
        Start = 1'b1; Bear = 12'h000; Ship = 8'hFF;
      end else if (k == mid_k) begin
        Start = 1'b0;
      end
      if (PdoClk[0] && !prev_clk[0]) begin
        cap_bear = {cap_bear[10:0], PdoDat[0]};
        rise0++;
        if (first_rise < 0) first_rise = k;
      end
      if (PdoClk[1] && !prev_clk[1]) begin
        cap_ship = {cap_ship[6:0], PdoDat[1]};
        rise1++;
      end
      if (rise0 > 8 && (PdoClk[1] || PdoDat[1])) ship_late = 1'b1;
      if (PdoLt == 2'b11) lt_cycles++;
      if (!Busy && !Done) busy_drop = 1'b1;
      if (Done) begin
        done_k    = k;
        done_busy = Busy;
        if (chain) begin
          Start = 1'b1; Bear = nb; Ship = ns;
        end
        break;
      end
      prev_clk = PdoClk;
    end
    if (chain) begin
      @(posedge Clk); #1;
      Start = 1'b0;
    end else begin
      @(posedge Clk); #1;
    end
  endtask

  task automatic check_frame(input string tag, input logic [11:0] eb, input logic [7:0] es);
    check({tag, "_bear_bits"}, 32'(cap_bear), 32'(eb));
    check({tag, "_ship_bits"}, 32'(cap_ship), 32'(es));
    check({tag, "_done_lat"}, 32'(done_k), 32'd100);
  endtask

  initial begin
    vecs[0] = '{12'hA5C, 8'h3E, 12'b1010_0101_1100, 8'b0011_1110};
    vecs[1] = '{12'hFFF, 8'h00, 12'b1111_1111_1111, 8'b0000_0000};
    vecs[2] = '{12'h000, 8'hFF, 12'b0000_0000_0000, 8'b1111_1111};
    vecs[3] = '{12'h801, 8'h81, 12'b1000_0000_0001, 8'b1000_0001};
    vecs[4] = '{12'h3C7, 8'h5A, 12'b0011_1100_0111, 8'b0101_1010};

    nReset = 1'b0; Start = 1'b0; Bear = '0; Ship = '0;
    #12;
    check("reset_outputs", 32'({Busy, Done, FrameCount, PdoDat, PdoClk, PdoLt}), 32'd0);
    repeat (2) @(posedge Clk);
    #1 nReset = 1'b1;
    repeat (2) @(posedge Clk);
    #1;
    check("idle_outputs", 32'({Busy, Done, FrameCount, PdoDat, PdoClk, PdoLt}), 32'd0);

    // table-driven frames from idle
    for (int i = 0; i < 5; i++) begin
      kick(vecs[i].bear, vecs[i].ship);
      check("first_bit", 32'({Busy, PdoDat}), 32'({1'b1, vecs[i].exp_ship[7], vecs[i].exp_bear[11]}));
      observe(-10, 1'b0, '0, '0);
      check_frame("tbl", vecs[i].exp_bear, vecs[i].exp_ship);
      check("tbl_first_rise", 32'(first_rise), 32'd4);
      check("tbl_rises", 32'({rise0[7:0], rise1[7:0]}), 32'({8'd12, 8'd8}));
      check("tbl_lt_cycles", 32'(lt_cycles), 32'd4);
      check("tbl_ship_quiet", 32'(ship_late), 32'd0);
      check("tbl_busy_held", 32'({busy_drop, done_busy}), 32'd0);
      check("tbl_frame_count", 32'(FrameCount), 32'(i + 1));
    end

    // Start mid-frame is dropped; Bear/Ship change has no effect
    kick(12'hA5C, 8'h3E);
    observe(50, 1'b0, '0, '0);
    check_frame("ignored_start", 12'hA5C, 8'h3E);
    begin
      int extra = 0;
      for (int k = 0; k < 120; k++) begin
        @(posedge Clk); #1;
        if (Done || Busy) extra++;
      end
      check("single_done", 32'(extra), 32'd0);
    end
    check("fc_after_ignore", 32'(FrameCount), 32'd6);

    // back-to-back frames via Start in the Done cycle
    kick(12'hA5C, 8'h3E);
    observe(-10, 1'b1, 12'hFFF, 8'h00);
    check_frame("chain1", 12'hA5C, 8'h3E);
    check("chain_busy_in_done", 32'(done_busy), 32'd0);
    check("chain_first_bit", 32'({Busy, PdoDat}), 32'({1'b1, 1'b0, 1'b1}));
    observe(-10, 1'b0, '0, '0);
    check_frame("chain2", 12'hFFF, 8'h00);
    check("chain_rises", 32'({rise0[7:0], rise1[7:0]}), 32'({8'd12, 8'd8}));
    check("fc_after_chain", 32'(FrameCount), 32'd8);

    // asynchronous reset mid-frame
    kick(12'h3C7, 8'h5A);
    repeat (39) @(posedge Clk);
    #1;
    check("busy_before_reset", 32'(Busy), 32'd1);
    #2 nReset = 1'b0;
    #1;
    check("async_reset_outputs", 32'({Busy, Done, FrameCount, PdoDat, PdoClk, PdoLt}), 32'd0);
    repeat (2) @(posedge Clk);
    #1 nReset = 1'b1;
    begin
      int activity = 0;
      for (int k = 0; k < 120; k++) begin
        @(posedge Clk); #1;
        if (Done || Busy || PdoLt != 2'b00 || PdoClk != 2'b00) activity++;
      end
      check("no_frame_after_reset", 32'(activity), 32'd0);
    end
    kick(12'hA5C, 8'h3E);
    observe(-10, 1'b0, '0, '0);
    check_frame("post_reset", 12'hA5C, 8'h3E);
    check("fc_post_reset", 32'(FrameCount), 32'd1);

    // 255 more frames: 256 Done pulses since reset, counter wraps to 0
    for (int i = 0; i < 255; i++) begin
      logic [11:0] b;
      logic [7:0]  s;
      b = 12'(i * 293 + 17);
      s = 8'(i * 59 + 3);
      kick(b, s);
      observe(-10, 1'b0, '0, '0);
      check("loopback", 32'({cap_bear, cap_ship}), 32'({b, s}));
      if (i == 253) check("fc_255", 32'(FrameCount), 32'd255);
    end
    check("fc_wrap", 32'(FrameCount), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
